// File: rtl/score_keeper.sv
// Flappy-bird score keeper: frame-tick derivation from vs, game FSM, per-pipe pass counting, best score.
// Build option: define SCORE_BCD_EN to hold score/best as two packed BCD digits (max 99); default is binary (max 255).
module score_keeper (
    input  logic             Clk,
    input  logic             SoftReset,
    input  logic             vs,
    input  logic             gameOn,
    input  logic [9:0]       BirdX,
    input  logic [3:0][12:0] pipeX,
    input  logic [3:0][12:0] pipeWidth,
    output logic [7:0]       score,
    output logic [7:0]       best,
    output logic [3:0][3:0]  digits,
    output logic             new_best,
    output logic             pass_pulse
);

    localparam int unsigned NPIPE = 4;
    localparam int unsigned RW    = 14;
    localparam int unsigned SW    = 8;
`ifdef SCORE_BCD_EN
    localparam logic [SW-1:0] SCORE_MAX = 8'h99;
`else
    localparam logic [SW-1:0] SCORE_MAX = 8'hFF;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        OVER    = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_vs_meta;
    logic                r_vs_sync;
    logic                r_vs_prev;
    logic                r_tick;
    logic                r_game_prev;
    logic                r_low_seen;
    logic [NPIPE-1:0]    r_arm;
    logic [NPIPE-1:0]    w_arm_next;
    logic [NPIPE-1:0]    w_ge;
    logic [NPIPE-1:0]    w_pass;
    logic [RW-1:0]       w_right [NPIPE];
    logic [2:0]          w_npass;
    logic [SW-1:0]       r_score;
    logic [SW-1:0]       w_score_next;
    logic [SW-1:0]       w_score_inc;
    logic [SW-1:0]       r_best;
    logic [SW-1:0]       w_best_next;
    logic                r_new_best;
    logic                w_new_best_next;
    logic                r_pass_pulse;
    logic                w_pass_pulse_next;
    logic                w_start;
    logic                w_fall;

    // Saturating add of 0..4 to the score in the active number format.
    function automatic logic [SW-1:0] sat_add(input logic [SW-1:0] s, input logic [2:0] n);
`ifdef SCORE_BCD_EN
        logic [4:0] lo_sum;
        logic [3:0] lo;
        logic       carry;
        lo_sum = 5'(s[3:0]) + 5'(n);
        if (lo_sum > 5'd9) begin
            lo    = 4'(lo_sum - 5'd10);
            carry = 1'b1;
        end else begin
            lo    = 4'(lo_sum);
            carry = 1'b0;
        end
        if (carry && (s[7:4] == 4'd9)) begin
            return SCORE_MAX;
        end
        return {4'(s[7:4] + 4'(carry)), lo};
`else
        logic [SW:0] sum;
        sum = (SW+1)'(s) + (SW+1)'(n);
        if (sum > (SW+1)'(SCORE_MAX)) begin
            return SCORE_MAX;
        end
        return sum[SW-1:0];
`endif
    endfunction

    // vs synchronizer and registered rising-edge frame tick.
    always_ff @(posedge Clk or posedge SoftReset) begin
        if (SoftReset) begin
            r_vs_meta <= 1'b0;
            r_vs_sync <= 1'b0;
            r_vs_prev <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_vs_meta <= vs;
            r_vs_sync <= r_vs_meta;
            r_vs_prev <= r_vs_sync;
            r_tick    <= r_vs_sync & ~r_vs_prev;
        end
    end

    // gameOn is only seen on ticks; a start also needs a low sample since reset,
    // so a level held high across SoftReset does not relaunch a game.
    always_ff @(posedge Clk or posedge SoftReset) begin
        if (SoftReset) begin
            r_game_prev <= 1'b0;
            r_low_seen  <= 1'b0;
        end else if (r_tick) begin
            r_game_prev <= gameOn;
            if (!gameOn) begin
                r_low_seen <= 1'b1;
            end
        end
    end

    assign w_start = r_tick & gameOn & ~r_game_prev & r_low_seen;
    assign w_fall  = r_tick & ~gameOn & r_game_prev;

    // Pipe right edges and pass detection at 14 bits.
    always_comb begin
        for (int i = 0; i < int'(NPIPE); i++) begin
            w_right[i] = RW'(pipeX[i]) + RW'(pipeWidth[i]);
            w_ge[i]    = (w_right[i] >= RW'(BirdX));
            w_pass[i]  = r_arm[i] & ~w_ge[i];
        end
    end

    assign w_npass     = 3'(w_pass[0]) + 3'(w_pass[1]) + 3'(w_pass[2]) + 3'(w_pass[3]);
    assign w_score_inc = sat_add(r_score, w_npass);

    always_ff @(posedge Clk or posedge SoftReset) begin
        if (SoftReset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and next register values; passes are ignored outside PLAYING ticks.
    always_comb begin
        w_state_next      = r_state;
        w_arm_next        = r_arm;
        w_score_next      = r_score;
        w_best_next       = r_best;
        w_new_best_next   = r_new_best;
        w_pass_pulse_next = 1'b0;
        case (r_state)
            IDLE, OVER: begin
                if (w_start) begin
                    w_state_next    = PLAYING;
                    w_score_next    = '0;
                    w_new_best_next = 1'b0;
                    w_arm_next      = w_ge;
                end
            end
            PLAYING: begin
                if (w_fall) begin
                    w_state_next = OVER;
                end else if (r_tick) begin
                    w_arm_next        = w_ge;
                    w_score_next      = w_score_inc;
                    w_pass_pulse_next = |w_pass;
                    if (w_score_inc > r_best) begin
                        w_best_next     = w_score_inc;
                        w_new_best_next = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge SoftReset) begin
        if (SoftReset) begin
            r_arm        <= '0;
            r_score      <= '0;
            r_best       <= '0;
            r_new_best   <= 1'b0;
            r_pass_pulse <= 1'b0;
        end else begin
            r_arm        <= w_arm_next;
            r_score      <= w_score_next;
            r_best       <= w_best_next;
            r_new_best   <= w_new_best_next;
            r_pass_pulse <= w_pass_pulse_next;
        end
    end

    assign score      = r_score;
    assign best       = r_best;
    assign new_best   = r_new_best;
    assign pass_pulse = r_pass_pulse;
    assign digits[0]  = r_score[3:0];
    assign digits[1]  = r_score[7:4];
    assign digits[2]  = r_best[3:0];
    assign digits[3]  = r_best[7:4];

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed game scenarios plus random pipes, checked against a counting model.
module tb_score_keeper;

`ifdef SCORE_BCD_EN
    localparam int SMAX = 99;
`else
    localparam int SMAX = 255;
`endif

    logic             Clk;
    logic             SoftReset;
    logic             vs;
    logic             gameOn;
    logic [9:0]       BirdX;
    logic [3:0][12:0] pipeX;
    logic [3:0][12:0] pipeWidth;
    logic [7:0]       score;
    logic [7:0]       best;
    logic [3:0][3:0]  digits;
    logic             new_best;
    logic             pass_pulse;

    int total = 0;
    int bad   = 0;
    int pp_cnt = 0;

    // Model state, in plain decimal counts.
    int m_score, m_best;
    bit m_play, m_nb, m_prev, m_low, m_pulse;
    bit m_arm [4];

    score_keeper dut (
        .Clk        (Clk),
        .SoftReset  (SoftReset),
        .vs         (vs),
        .gameOn     (gameOn),
        .BirdX      (BirdX),
        .pipeX      (pipeX),
        .pipeWidth  (pipeWidth),
        .score      (score),
        .best       (best),
        .digits     (digits),
        .new_best   (new_best),
        .pass_pulse (pass_pulse)
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    always @(negedge Clk) if (pass_pulse === 1'b1) pp_cnt++;

    function automatic int enc(input int v);
`ifdef SCORE_BCD_EN
        return (v / 10) * 16 + (v % 10);
`else
        return v;
`endif
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_score = 0; m_best = 0; m_play = 0; m_nb = 0;
        m_prev = 0; m_low = 0; m_pulse = 0;
        for (int i = 0; i < 4; i++) m_arm[i] = 0;
    endtask

    task automatic model_tick(input bit gon);
        bit ge [4];
        int n;
        n = 0;
        m_pulse = 0;
        for (int i = 0; i < 4; i++)
            ge[i] = (int'(pipeX[i]) + int'(pipeWidth[i])) >= int'(BirdX);
        if (gon && !m_prev && m_low) begin
            m_play = 1; m_score = 0; m_nb = 0;
            for (int i = 0; i < 4; i++) m_arm[i] = ge[i];
        end else if (m_play && !gon) begin
            m_play = 0;
        end else if (m_play) begin
            for (int i = 0; i < 4; i++) begin
                if (m_arm[i] && !ge[i]) n++;
                m_arm[i] = ge[i];
            end
            m_score = (m_score + n > SMAX) ? SMAX : m_score + n;
            if (m_score > m_best) begin
                m_best = m_score;
                m_nb = 1;
            end
            m_pulse = (n > 0);
        end
        m_prev = gon;
        if (!gon) m_low = 1;
    endtask

    task automatic check_all(input string tag, input int pulses);
        chk({tag, ".score"}, int'(score), enc(m_score));
        chk({tag, ".best"}, int'(best), enc(m_best));
        chk({tag, ".new_best"}, int'(new_best), int'(m_nb));
        chk({tag, ".pulses"}, pulses, int'(m_pulse));
        chk({tag, ".digits"}, int'(digits), enc(m_best) * 256 + enc(m_score));
    endtask

    // One vs period with gameOn held for its tick.
    task automatic frame(input string tag, input bit gon);
        int pp0;
        gameOn = gon;
        pp0 = pp_cnt;
        vs = 1'b1;
        repeat (6) @(negedge Clk);
        vs = 1'b0;
        repeat (4) @(negedge Clk);
        model_tick(gon);
        check_all(tag, pp_cnt - pp0);
    endtask

    task automatic set_right(input int i, input int r);
        pipeWidth[i] = 13'(10);
        pipeX[i]     = 13'(r - 10);
    endtask

    task automatic far_pipes();
        for (int i = 0; i < 4; i++) set_right(i, 2000);
    endtask

    // n single-pipe passes on pipe 0 (arm frame then pass frame).
    task automatic pass_n(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            set_right(0, 120); frame(tag, 1'b1);
            set_right(0, 90);  frame(tag, 1'b1);
        end
    endtask

    initial begin
        SoftReset = 1'b1;
        vs = 1'b0;
        gameOn = 1'b0;
        BirdX = 10'd100;
        far_pipes();
        model_reset();
        repeat (3) @(negedge Clk);
        chk("rst.score", int'(score), 0);
        chk("rst.best", int'(best), 0);
        chk("rst.new_best", int'(new_best), 0);
        chk("rst.pass_pulse", int'(pass_pulse), 0);
        chk("rst.digits", int'(digits), 0);
        SoftReset = 1'b0;
        repeat (2) @(negedge Clk);

        // First pass: right 120 -> 99 with bird at 100.
        frame("idle", 1'b0);
        set_right(0, 120); frame("start", 1'b1);
        frame("arm", 1'b1);
        set_right(0, 99);  frame("pass1", 1'b1);
        chk("pass1.score_is_1", int'(score), 1);

        // Parked behind the bird: no recount.
        set_right(0, 90);
        for (int k = 0; k < 10; k++) frame("parked", 1'b1);
        chk("parked.score_is_1", int'(score), 1);

        // Game A reaches 7, game B ends at 5, game C reaches 8.
        pass_n("gameA", 6);
        frame("endA", 1'b0);
        set_right(0, 120); frame("overA", 1'b0);
        set_right(0, 90);  frame("startB_with_pass", 1'b1);
        chk("startB.score_zero", int'(score), 0);
        pass_n("gameB", 5);
        chk("gameB.new_best_low", int'(new_best), 0);
        frame("endB", 1'b0);
        frame("startC", 1'b1);
        pass_n("gameC", 8);
        chk("gameC.best_hi", int'(digits[3]), 0);
        chk("gameC.best_lo", int'(digits[2]), 8);

        // All four pipes together until the score saturates.
        for (int k = 0; k < 70; k++) begin
            for (int i = 0; i < 4; i++) set_right(i, 120);
            frame("sat.arm", 1'b1);
            for (int i = 0; i < 4; i++) set_right(i, 60 + i);
            frame("sat.pass", 1'b1);
        end
        chk("sat.score_max", int'(score), enc(SMAX));
        frame("endSat", 1'b0);
        far_pipes();
        frame("startD", 1'b1);
        pass_n("gameD", 3);

        // SoftReset in the middle of a vs period.
        vs = 1'b1;
        repeat (3) @(negedge Clk);
        SoftReset = 1'b1;
        #1;
        chk("midrst.score", int'(score), 0);
        chk("midrst.best", int'(best), 0);
        chk("midrst.new_best", int'(new_best), 0);
        chk("midrst.pass_pulse", int'(pass_pulse), 0);
        chk("midrst.digits", int'(digits), 0);
        model_reset();
        @(negedge Clk);
        SoftReset = 1'b0;
        vs = 1'b0;
        repeat (4) @(negedge Clk);
        pass_n("held_high", 3);
        chk("held_high.no_game", int'(score), 0);
        frame("relow", 1'b0);
        frame("restart", 1'b1);
        pass_n("after_rst", 2);

        // Random pipes, bird positions and gameOn toggles.
        for (int k = 0; k < 200; k++) begin
            bit gon;
            if ($urandom_range(0, 7) == 0) BirdX = 10'($urandom_range(100, 900));
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 9) == 0) begin
                    pipeX[i]     = 13'($urandom);
                    pipeWidth[i] = 13'($urandom);
                end else begin
                    pipeWidth[i] = 13'($urandom_range(0, 40));
                    pipeX[i]     = 13'($urandom_range(int'(BirdX) - 60, int'(BirdX) + 20));
                end
            end
            gon = ($urandom_range(0, 9) == 0) ? !m_prev : m_prev;
            if (!m_low) gon = 1'b0;
            frame("rand", gon);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Clk  in  1  system clock, 50 MHz; reset SoftReset, asynchronous, active-high; clock Clk.
REQ-002 SoftReset  in  1  asynchronous active-high reset; clears all state, including best score.
REQ-003 vs  in  1  VGA vertical sync (pixel-clock domain); frame cadence source.
REQ-004 gameOn  in  1  level; high while a game is running.
REQ-005 BirdX  in  10  bird left edge, pixels.
REQ-006 pipeX  in  4x13 packed  current left edge of each of 4 pipes.
REQ-007 pipeWidth  in  4x13 packed  width of each pipe.
REQ-008 score  out  8  current-game score, registered.
REQ-009 best  out  8  best score since SoftReset, registered.
REQ-010 digits  out  4x4  display nibbles: [0] score low, [1] score high, [2] best low, [3] best high.
REQ-011 new_best  out  1  high once best has been raised during the current game.
REQ-012 pass_pulse  out  1  one-Clk pulse per frame tick in which at least one pipe is passed.

Function
REQ-013 vs SHALL pass through a 2-flop synchronizer; a rising edge of the synchronized signal SHALL produce frame_tick, one Clk wide, registered (3 Clk latency from vs edge, ±1).
REQ-014 gameOn SHALL be sampled only on frame_tick; its edges are detected against the value sampled on the previous tick.
REQ-015 FSM states IDLE, PLAYING, OVER; reset state IDLE.
REQ-016 IDLE/OVER -> PLAYING on tick with sampled gameOn rising; on the same Clk: score=0, new_best=0, all arm bits recomputed.
REQ-017 PLAYING -> OVER on tick with sampled gameOn falling; score and best held.
REQ-018 Per pipe i: right = pipeX[i]+pipeWidth[i], computed at 14 bits; BirdX zero-extended to 14 bits.
REQ-019 arm[i] SHALL be set on any PLAYING tick with right >= BirdX.
REQ-020 Pipe i is passed on a PLAYING tick with arm[i]=1 and right < BirdX; arm[i] SHALL clear on that tick (one count per pipe pass).
REQ-021 Per tick, score SHALL increase by the number of pipes passed (0..4), saturating at SCORE_MAX; no wrap-around.
REQ-022 Score and best are visible 1 Clk after the tick that caused the change.
REQ-023 If score_next > best, best SHALL take score_next on the same Clk edge, and new_best SHALL be set.
REQ-024 A tick carrying both gameOn rising and pipe passes SHALL only start the new game (score=0); passes are ignored.
REQ-025 pass_pulse SHALL assert 1 Clk after a counting tick, for exactly 1 Clk.
REQ-026 In IDLE/OVER, arm bits, score and pass_pulse SHALL not change except as stated in REQ-016.

Reset
REQ-027 On SoftReset, asynchronously: state=IDLE, score=0, best=0, new_best=0, pass_pulse=0, arm=0, synchronizer and edge registers=0, digits=0.
REQ-028 SoftReset asserted mid-game SHALL abort the game with no best update; after release the block waits in IDLE for a gameOn rising edge.

Configuration
REQ-029 Macro SCORE_BCD_EN defined: score/best held as 2 packed BCD digits; SCORE_MAX=99; increments use BCD carry; digits are the BCD digits.
REQ-030 SCORE_BCD_EN undefined: score/best are binary; SCORE_MAX=255; digits are the raw nibbles.

Verification
REQ-031 Reset, gameOn=1 on tick, BirdX=100, pipe0 right moves 120->99 over 2 ticks -> score=1, pass_pulse single pulse, best=1, new_best=1.
REQ-032 Pipe stays at right=90 for 10 ticks after passing -> score stays 1 (no re-count until right>=BirdX re-arms it).
REQ-033 Binary build, score=254, 2 pipes pass in one tick -> score=255 (saturated); BCD build, score=0x98, 3 pass -> 0x99.
REQ-034 Game ends at score 5, best 7; new game, reach 8 -> best=8, new_best=1; digits[3:2]=0,8.
REQ-035 SoftReset pulse mid-tick during PLAYING, score=3 -> all outputs 0 immediately; state IDLE; gameOn held high produces no new game until it falls and rises again.
REQ-036 gameOn rising and pipe passing on same tick -> score=0, pass_pulse=0.
